// File: rtl/vga_pixel_stage.sv
// -----------------------------------------------------------------------------
// vga_pixel_stage
//
// Pixel-colour stage that sits directly behind the VGA timing controller.
// It turns the controller's raster position into a colour using a small
// test-pattern generator, overlays an optionally blinking rectangular cursor,
// and delays every timing signal through the same two-register pipeline so
// that colour and sync reach the DAC pins aligned.
//
// Pipeline:
//   stage 1 : registers row, column, display_enable and the sync/blank inputs
//   stage 2 : computes the colour from the stage-1 registers and the shadow
//             configuration, and registers every output
//   Latency is a fixed 2 cycles for all outputs in every mode.
//
// Configuration is double-buffered: the cfg_* inputs are copied into shadow
// registers only on a frame-start cycle (display_enable=1, row=0, column=0),
// so a frame is always drawn with one consistent configuration.
//
// Ports:
//   clk            pixel clock, the only clock
//   rst            synchronous reset, active high
//   display_enable active-video flag from the timing controller
//   row, column    current raster position (12 bits each)
//   h_sync_in, v_sync_in, n_blank_in, n_sync_in
//                  timing controller outputs, passed through unaltered
//   cfg_mode       pattern select: 0 solid, 1 bars, 2 checker, 3 grid
//   cfg_color      {R,G,B} foreground colour
//   cfg_cur_x/y/w/h cursor rectangle (top-left corner, width, height)
//   cfg_cur_en     cursor enable
//   cfg_blink_en   cursor blink enable
//   red, green, blue  registered pixel colour
//   h_sync, v_sync, n_blank, n_sync, de_out
//                  timing outputs delayed by 2 cycles
//   frame_count    frames since reset (wraps 255 -> 0), pipelined with video
// -----------------------------------------------------------------------------
module vga_pixel_stage #(
    parameter int COLOR_W    = 8,
    parameter int BAR_SHIFT  = 6,
    parameter int CHK_SHIFT  = 4,
    parameter int GRID_SHIFT = 5,
    parameter int BLINK_BIT  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   display_enable,
    input  logic [11:0]            row,
    input  logic [11:0]            column,
    input  logic                   h_sync_in,
    input  logic                   v_sync_in,
    input  logic                   n_blank_in,
    input  logic                   n_sync_in,
    input  logic [1:0]             cfg_mode,
    input  logic [3*COLOR_W-1:0]   cfg_color,
    input  logic [11:0]            cfg_cur_x,
    input  logic [11:0]            cfg_cur_y,
    input  logic [11:0]            cfg_cur_w,
    input  logic [11:0]            cfg_cur_h,
    input  logic                   cfg_cur_en,
    input  logic                   cfg_blink_en,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   n_blank,
    output logic                   n_sync,
    output logic                   de_out,
    output logic [7:0]             frame_count
);

    localparam int PIX_W = 3 * COLOR_W;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_GRID    = 2'd3
    } pattern_mode_e;

    // One frame's worth of configuration, captured as a unit at frame start.
    typedef struct packed {
        pattern_mode_e    mode;
        logic [PIX_W-1:0] color;
        logic [11:0]      cur_x;
        logic [11:0]      cur_y;
        logic [11:0]      cur_w;
        logic [11:0]      cur_h;
        logic             cur_en;
        logic             blink_en;
    } shadow_cfg_t;

    // -------------------------------------------------------------------------
    // Frame start detection and shadow configuration
    // -------------------------------------------------------------------------
    logic        frame_start;
    shadow_cfg_t cfg_live;
    shadow_cfg_t shadow;
    logic [7:0]  frame_cnt;

    assign frame_start = display_enable && (row == 12'd0) && (column == 12'd0);

    always_comb begin
        cfg_live.mode     = pattern_mode_e'(cfg_mode);
        cfg_live.color    = cfg_color;
        cfg_live.cur_x    = cfg_cur_x;
        cfg_live.cur_y    = cfg_cur_y;
        cfg_live.cur_w    = cfg_cur_w;
        cfg_live.cur_h    = cfg_cur_h;
        cfg_live.cur_en   = cfg_cur_en;
        cfg_live.blink_en = cfg_blink_en;
    end

    // The shadows and the counter update on the same edge that captures the
    // frame-start pixel into stage 1, so that pixel is coloured in stage 2
    // with the new configuration and the new frame number. The pixel just
    // before it is coloured on that same edge and still sees the old values.
    // NOTE: every clocked register uses non-blocking (<=) assignments so all
    // flops sample their inputs from before the edge, whatever the statement
    // order; a blocking assignment here would leak new values into later logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            shadow    <= cfg_live;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: raster position and timing capture
    // -------------------------------------------------------------------------
    logic [11:0] s1_row;
    logic [11:0] s1_col;
    logic        s1_de;
    logic        s1_h_sync;
    logic        s1_v_sync;
    logic        s1_n_blank;
    logic        s1_n_sync;

    // Reset values mirror the idle state of the timing lines (syncs and n_sync
    // inactive high, blanking active), so the outputs are quiet straight out
    // of reset rather than after the pipeline has flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_row     <= 12'd0;
            s1_col     <= 12'd0;
            s1_de      <= 1'b0;
            s1_h_sync  <= 1'b1;
            s1_v_sync  <= 1'b1;
            s1_n_blank <= 1'b0;
            s1_n_sync  <= 1'b1;
        end else begin
            s1_row     <= row;
            s1_col     <= column;
            s1_de      <= display_enable;
            s1_h_sync  <= h_sync_in;
            s1_v_sync  <= v_sync_in;
            s1_n_blank <= n_blank_in;
            s1_n_sync  <= n_sync_in;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational colour: pattern, cursor overlay, blanking
    // -------------------------------------------------------------------------
    logic [2:0]       bar_idx;
    logic             checker_dark;
    logic             on_grid;
    logic [PIX_W-1:0] pattern_pix;

    assign bar_idx      = s1_col[BAR_SHIFT+2 -: 3];
    assign checker_dark = s1_col[CHK_SHIFT] ^ s1_row[CHK_SHIFT];
    assign on_grid      = (s1_col[GRID_SHIFT-1:0] == '0) ||
                          (s1_row[GRID_SHIFT-1:0] == '0);

    // NOTE: the output is given a default before the case so every path
    // assigns it; a missing branch would otherwise infer a latch.
    always_comb begin
        pattern_pix = '0;
        case (shadow.mode)
            MODE_SOLID:   pattern_pix = shadow.color;
            // Bar index bits map straight onto R, G, B: black, blue, green,
            // cyan, red, magenta, yellow, white from left to right.
            MODE_BARS:    pattern_pix = {{COLOR_W{bar_idx[2]}},
                                         {COLOR_W{bar_idx[1]}},
                                         {COLOR_W{bar_idx[0]}}};
            MODE_CHECKER: pattern_pix = checker_dark ? '0 : shadow.color;
            MODE_GRID:    pattern_pix = on_grid ? shadow.color : '0;
            default:      pattern_pix = '0;
        endcase
    end

    // Rectangle limits are formed one bit wider than the raster coordinates,
    // so a cursor reaching past column/row 4095 does not wrap round onto the
    // left or top edge. A zero width or height gives an empty interval.
    logic [12:0] cur_x_end;
    logic [12:0] cur_y_end;
    logic        cur_hit;
    logic        cur_visible;

    assign cur_x_end = {1'b0, shadow.cur_x} + {1'b0, shadow.cur_w};
    assign cur_y_end = {1'b0, shadow.cur_y} + {1'b0, shadow.cur_h};

    assign cur_hit = (s1_col >= shadow.cur_x) && ({1'b0, s1_col} < cur_x_end) &&
                     (s1_row >= shadow.cur_y) && ({1'b0, s1_row} < cur_y_end);

    // Blinking hides the cursor for the half of each blink period in which
    // the selected frame-counter bit is set.
    assign cur_visible = shadow.cur_en &&
                         (!shadow.blink_en || !frame_cnt[BLINK_BIT]);

    logic [PIX_W-1:0] next_pix;

    always_comb begin
        next_pix = pattern_pix;
        if (cur_hit && cur_visible) begin
            next_pix = ~pattern_pix;
        end
        // Outside active video the DAC must see black, whatever was drawn.
        if (!s1_de) begin
            next_pix = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            n_blank     <= 1'b0;
            n_sync      <= 1'b1;
            de_out      <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            red         <= next_pix[3*COLOR_W-1:2*COLOR_W];
            green       <= next_pix[2*COLOR_W-1:COLOR_W];
            blue        <= next_pix[COLOR_W-1:0];
            h_sync      <= s1_h_sync;
            v_sync      <= s1_v_sync;
            n_blank     <= s1_n_blank;
            n_sync      <= s1_n_sync;
            de_out      <= s1_de;
            // Sampled alongside the colour so the reported frame number lines
            // up with the pixel stream it belongs to.
            frame_count <= frame_cnt;
        end
    end

endmodule
